// File: rtl/fpga_link_pkg.sv
// Shared types and line levels for the FPGA-to-FPGA serial link.
// Used by both the TX and RX controllers.
package fpga_link_pkg;

  localparam int DATA_BITS = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } link_state_e;

  function automatic logic even_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/fpga_tx_controller_if.sv
// Byte handshake between the transmitting logic and the TX controller.
// The master side is the requester and the slave side is the controller.
interface fpga_tx_controller_if;

  logic [fpga_link_pkg::DATA_BITS-1:0] tx_data;
  logic                                tx_valid;
  logic                                tx_ready;
  logic                                tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );

endinterface

// File: rtl/fpga_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps.
// It flags the last cycle of the period and the cycle before it.
module fpga_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE =
    CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_end = (cnt_q == LAST);
  assign pre_end = !clear && (cnt_q == PRE);

endmodule

// File: rtl/fpga_tx_controller.sv
// TX sequencer: loads/shifts the external byte register and frames it.
// Define FPGA_TX_PARITY_EN to insert an even-parity bit before the stop.
module fpga_tx_controller
  import fpga_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  fpga_tx_controller_if.slave  tx,
  output logic [DATA_BITS-1:0] sr_data,
  output logic                 sr_load,
  output logic                 sr_shift,
  input  logic                 sr_bit,
  output logic                 serial_out
);

`ifdef FPGA_TX_PARITY_EN
  localparam link_state_e AFTER_DATA = PARITY;
`else
  localparam link_state_e AFTER_DATA = STOP;
`endif

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  link_state_e state_q, state_d;

  logic [2:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] sr_data_q;

  logic ready_q, done_q, load_q, shift_q;
  logic line_q, in_data_q;
  logic line_d;

  logic bit_end, pre_end, state_chg;
  logic accept, last_bit, last_stop;

  assign accept    = (state_q == IDLE) && tx.tx_valid;
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign last_stop = (stop_cnt_q == LAST_STOP);
  assign state_chg = (state_d != state_q);

  fpga_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_chg),
    .bit_end (bit_end),
    .pre_end (pre_end)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tx.tx_valid) state_d = LOAD;
      LOAD:  state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && last_bit) begin
          state_d = AFTER_DATA;
        end
      end
`ifdef FPGA_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        if (bit_end && last_stop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = IDLE_LEVEL;
    case (state_d)
      START: line_d = START_LEVEL;
`ifdef FPGA_TX_PARITY_EN
      PARITY: line_d = even_parity(sr_data_q);
`endif
      default: line_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      sr_data_q  <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      line_q     <= IDLE_LEVEL;
      in_data_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      done_q    <= (state_q == STOP) &&
                   (state_d == IDLE);
      load_q    <= (state_d == LOAD);
      shift_q   <= (state_q == DATA) && pre_end;
      line_q    <= line_d;
      in_data_q <= (state_d == DATA);
      if (accept) begin
        sr_data_q <= tx.tx_data;
      end
      if (state_chg) begin
        bit_cnt_q <= '0;
      end else if (state_q == DATA && bit_end) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (state_chg) begin
        stop_cnt_q <= 1'b0;
      end else if (state_q == STOP && bit_end) begin
        stop_cnt_q <= stop_cnt_q + 1'b1;
      end
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx.tx_done  = done_q;
  assign sr_data     = sr_data_q;
  assign sr_load     = load_q;
  assign sr_shift    = shift_q;

  // The register shifts on the edge that ends each bit, so its MSB
  // is passed straight through to keep the bit aligned to that edge.
  assign serial_out = in_data_q ? sr_bit : line_q;

endmodule

// File: tb/tb_fpga_tx_controller.sv
// Self-checking bench for fpga_tx_controller with a model shift register.
// Expected frames are rebuilt per byte from the line format rules.
module tb_fpga_tx_controller;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FPGA_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 1 + (9 + SB + PB) * CPB;
  localparam int NRND  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sr_data;
  logic       sr_load;
  logic       sr_shift;
  logic       sr_bit;
  logic       serial_out;
  logic [7:0] sr_q = 8'h00;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;

  fpga_tx_controller_if txi ();

  fpga_tx_controller #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx         (txi.slave),
    .sr_data    (sr_data),
    .sr_load    (sr_load),
    .sr_shift   (sr_shift),
    .sr_bit     (sr_bit),
    .serial_out (serial_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sr_load) begin
      sr_q <= sr_data;
    end else if (sr_shift) begin
      sr_q <= {sr_q[6:0], 1'b0};
    end
  end

  assign sr_bit = sr_q[7];

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends one byte from an idle negedge; returns at the tx_done negedge.
  // With hold set, tx_valid stays high carrying nb for the next call.
  task automatic xfer(
    input logic [7:0] b,
    input bit         hold,
    input logic [7:0] nb
  );
    logic [63:0] gl, gd, gr, gld, gs, ov;
    logic [63:0] el, es;
    int i;
    txi.tx_valid = 1'b1;
    txi.tx_data  = b;
    check("ready_pre", 64'(txi.tx_ready), 64'd1);
    acc_cyc = cyc;
    @(posedge clock);
    @(negedge clock);
    if (hold) txi.tx_data = nb;
    else txi.tx_valid = 1'b0;
    check("sr_data", 64'(sr_data), 64'(b));
    gl = '0; gd = '0; gr = '0;
    gld = '0; gs = '0; ov = '0;
    for (int k = 0; k <= FRAME; k++) begin
      if (k > 0) @(negedge clock);
      gl[k]  = serial_out;
      gd[k]  = txi.tx_done;
      gr[k]  = txi.tx_ready;
      gld[k] = sr_load;
      gs[k]  = sr_shift;
      ov[k]  = sr_load & sr_shift;
    end
    el = '0;
    es = '0;
    for (int k = 0; k <= FRAME; k++) begin
      if (k == 0) begin
        el[k] = 1'b1;
      end else if (k <= CPB) begin
        el[k] = 1'b0;
      end else if (k <= 9 * CPB) begin
        i = (k - CPB - 1) / CPB;
        el[k] = b[7 - i];
        es[k] = ((k - CPB - 1) % CPB) == CPB - 1;
      end else if (k <= 9 * CPB + PB * CPB) begin
        el[k] = ^b;
      end else begin
        el[k] = 1'b1;
      end
    end
    check("line", gl, el);
    check("done", gd, 64'd1 << FRAME);
    check("ready", gr, 64'd1 << FRAME);
    check("load", gld, 64'd1);
    check("shift", gs, es);
    check("shift_cnt", 64'($countones(gs)), 64'd8);
    check("load_shift_ovl", ov, 64'd0);
  endtask

  initial begin
    logic [7:0]  rb [NRND+1];
    int unsigned t1;
    logic        done_seen;
    bit          h;

    txi.tx_valid = 1'b0;
    txi.tx_data  = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_outs",
          64'({serial_out, txi.tx_ready, txi.tx_done,
               sr_load, sr_shift}),
          64'(5'b11000));
    check("rst_sr_data", 64'(sr_data), 64'd0);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      check("idle",
            64'({serial_out, txi.tx_ready, txi.tx_done,
                 sr_load, sr_shift}),
            64'(5'b11000));
    end

    xfer(8'hA5, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    xfer(8'h07, 1'b0, 8'h00);
    repeat (2) @(negedge clock);

    xfer(8'h3C, 1'b1, 8'hFF);
    t1 = acc_cyc;
    xfer(8'hFF, 1'b0, 8'h00);
    check("b2b_gap", 64'(acc_cyc - t1), 64'(FRAME + 1));
    repeat (2) @(negedge clock);

    xfer(8'h80, 1'b1, 8'h11);
    t1 = acc_cyc;
    xfer(8'h11, 1'b0, 8'h00);
    check("hold_gap", 64'(acc_cyc - t1), 64'(FRAME + 1));
    repeat (2) @(negedge clock);

    txi.tx_valid = 1'b1;
    txi.tx_data  = 8'h5A;
    @(posedge clock);
    @(negedge clock);
    txi.tx_valid = 1'b0;
    repeat (CPB + 1 + 3 * CPB) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_line",
          64'({serial_out, txi.tx_ready, txi.tx_done}),
          64'(3'b110));
    @(negedge clock);
    check("abort_hold",
          64'({serial_out, txi.tx_ready, txi.tx_done}),
          64'(3'b110));
    @(negedge clock);
    reset = 1'b1;
    done_seen = 1'b0;
    repeat (FRAME + 5) begin
      @(negedge clock);
      done_seen = done_seen | txi.tx_done;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_idle",
          64'({serial_out, txi.tx_ready}), 64'(2'b11));
    xfer(8'hC3, 1'b0, 8'h00);

    for (int n = 0; n <= NRND; n++) begin
      rb[n] = 8'($urandom);
    end
    for (int n = 0; n < NRND; n++) begin
      h = (n < NRND - 1) && ($urandom_range(0, 1) == 1);
      xfer(rb[n], h, rb[n+1]);
      if (!h) begin
        repeat ($urandom_range(0, 4)) @(negedge clock);
      end
    end

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
